v_elem_seq: RTL and testbench



---
 rtl/v_elem_seq_if.sv | 31 +++
 rtl/v_elem_seq.sv | 106 ++++++++++
 tb/tb_v_elem_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/v_elem_seq_if.sv
// Command, read-issue and write-back signals between vector issue logic,
// the element sequencer and the banked vector register file.
interface v_elem_seq_if #(
    parameter int vlen_p  = 8,
    parameter int lanes_p = 4
);
    localparam int addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1;
    localparam int vl_width_lp   = $clog2(vlen_p + 1);

    logic                                    cmd_v_i;
    logic [vl_width_lp-1:0]                  cmd_vl_i;
    logic                                    cmd_we_i;
    logic                                    cmd_ready_o;
    logic                                    stall_i;
    logic [lanes_p-1:0][addr_width_lp-1:0]   r_addr_o;
    logic [lanes_p-1:0]                      r_v_o;
    logic [lanes_p-1:0][addr_width_lp-1:0]   w_addr_o;
    logic [lanes_p-1:0]                      w_en_o;
    logic                                    busy_o;
    logic                                    done_o;

    modport master (
        output cmd_v_i, cmd_vl_i, cmd_we_i, stall_i,
        input  cmd_ready_o, r_addr_o, r_v_o, w_addr_o, w_en_o, busy_o, done_o
    );

    modport slave (
        input  cmd_v_i, cmd_vl_i, cmd_we_i, stall_i,
        output cmd_ready_o, r_addr_o, r_v_o, w_addr_o, w_en_o, busy_o, done_o
    );
endinterface

// File: rtl/v_elem_seq.sv
// Vector element sequencer: walks a command's elements lanes_p per cycle and
// replays the issued reads as write-backs after a fixed wb_lat_p delay.
module v_elem_seq #(
    parameter int vlen_p   = 8,
    parameter int lanes_p  = 4,
    parameter int wb_lat_p = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    v_elem_seq_if.slave       io
);
    localparam int addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1;
    localparam int vl_width_lp   = $clog2(vlen_p + 1);
    localparam int drain_width_lp = $clog2(wb_lat_p + 1);

    localparam logic [vl_width_lp-1:0] vlen_c  = vl_width_lp'(vlen_p);
    localparam logic [vl_width_lp-1:0] lanes_c = vl_width_lp'(lanes_p);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                                state_r;
    logic [vl_width_lp-1:0]                vl_r;
    logic                                  we_r;
    logic [vl_width_lp-1:0]                base_r;   // element index of lane 0 this step
    logic [drain_width_lp-1:0]             drain_r;

    logic [wb_lat_p-1:0][lanes_p-1:0][addr_width_lp-1:0] pipe_addr_r;
    logic [wb_lat_p-1:0][lanes_p-1:0]                    pipe_en_r;

    logic [vl_width_lp-1:0] vl_in;
    logic [vl_width_lp-1:0] elem;
    logic                   last_step;

    assign vl_in     = (io.cmd_vl_i > vlen_c) ? vlen_c : io.cmd_vl_i;
    assign last_step = (base_r + lanes_c) >= vl_r;

    // Read issue is combinational on stall_i so a stalled cycle drops its valids at once.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        io.r_addr_o = '0;
        io.r_v_o    = '0;
        elem        = '0;
        if (state_r == ISSUE) begin
            for (int i = 0; i < lanes_p; i++) begin
                elem           = base_r + vl_width_lp'(i);
                io.r_addr_o[i] = elem[addr_width_lp-1:0];
                io.r_v_o[i]    = (elem < vl_r) & ~io.stall_i;
            end
        end
    end

    assign io.cmd_ready_o = (state_r == IDLE) & ~reset_i;
    assign io.busy_o      = (state_r != IDLE);
    assign io.done_o      = (state_r == DONE);
    assign io.w_addr_o    = pipe_addr_r[wb_lat_p-1];
    assign io.w_en_o      = pipe_en_r[wb_lat_p-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            vl_r        <= '0;
            we_r        <= 1'b0;
            base_r      <= '0;
            drain_r     <= '0;
            pipe_addr_r <= '0;
            pipe_en_r   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            pipe_addr_r[0] <= io.r_addr_o;
            pipe_en_r[0]   <= io.r_v_o & {lanes_p{we_r}};
            for (int s = 1; s < wb_lat_p; s++) begin
                pipe_addr_r[s] <= pipe_addr_r[s-1];
                pipe_en_r[s]   <= pipe_en_r[s-1];
            end

            unique case (state_r)
                IDLE: begin
                    if (io.cmd_v_i) begin
                        vl_r    <= vl_in;
                        we_r    <= io.cmd_we_i;
                        base_r  <= '0;
                        state_r <= (vl_in == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (!io.stall_i) begin
                        base_r <= base_r + lanes_c;
                        if (last_step) begin
                            state_r <= DRAIN;
                            drain_r <= drain_width_lp'(wb_lat_p);
                        end
                    end
                end
                DRAIN: begin
                    drain_r <= drain_r - 1'b1;
                    if (drain_r == drain_width_lp'(1)) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_v_elem_seq.sv
// Self-checking bench: per-cycle expectation tables built from a transaction
// schedule of each accepted command, compared against the DUT every cycle.
module tb_v_elem_seq;
    localparam int VLEN = 8;
    localparam int L    = 4;
    localparam int LAT  = 1;
    localparam int AW   = 3;
    localparam int VW   = 4;
    localparam int NCYC = 2048;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    v_elem_seq_if #(.vlen_p(VLEN), .lanes_p(L)) bus ();

    v_elem_seq #(.vlen_p(VLEN), .lanes_p(L), .wb_lat_p(LAT)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .io      (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int idle_from = 0;
    bit chk_en = 1'b0;

    logic [L-1:0]          exp_rv    [NCYC];
    logic [L-1:0][AW-1:0]  exp_raddr [NCYC];
    logic [L-1:0]          exp_wen   [NCYC];
    bit                    exp_done  [NCYC];
    bit                    exp_ready [NCYC];
    bit                    exp_busy  [NCYC];
    bit                    stall_tab [NCYC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, expv);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCYC; c++) begin
            exp_rv[c]    = '0;
            exp_raddr[c] = '0;
            exp_wen[c]   = '0;
            exp_done[c]  = 1'b0;
            exp_ready[c] = 1'b0;
            exp_busy[c]  = 1'b0;
        end
    endtask

    // Lay out the whole operation accepted in cycle a onto the expectation tables.
    task automatic model_accept(input int a, input int vl_req, input bit we);
        int vl, steps, k, t;
        vl = (vl_req > VLEN) ? VLEN : vl_req;
        if (vl == 0) begin
            exp_done[a+1] = 1'b1;
            idle_from = a + 2;
        end else begin
            steps = (vl + L - 1) / L;
            k = 0;
            t = a + 1;
            while (k < steps) begin
                for (int i = 0; i < L; i++) exp_raddr[t][i] = AW'(k*L + i);
                if (!stall_tab[t]) begin
                    for (int i = 0; i < L; i++) begin
                        if (k*L + i < vl) begin
                            exp_rv[t][i] = 1'b1;
                            if (we) exp_wen[t+LAT][i] = 1'b1;
                        end
                    end
                    k++;
                end
                t++;
            end
            exp_done[t-1+LAT+1] = 1'b1;
            idle_from = t - 1 + LAT + 2;
        end
    endtask

    // Drive one cycle's inputs, let the model see any accept, then advance.
    task automatic drive(input bit v, input int vl, input bit we);
        bit rdy;
        bus.cmd_v_i  = v;
        bus.cmd_vl_i = VW'(vl);
        bus.cmd_we_i = we;
        bus.stall_i  = stall_tab[cyc];
        rdy = (cyc >= idle_from);
        exp_ready[cyc] = rdy;
        exp_busy[cyc]  = !rdy;
        if (v && rdy) model_accept(cyc, vl, we);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) drive(1'b0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",  64'(bus.cmd_ready_o), 64'(exp_ready[cyc]));
            check("busy",   64'(bus.busy_o),      64'(exp_busy[cyc]));
            check("done",   64'(bus.done_o),      64'(exp_done[cyc]));
            check("r_v",    64'(bus.r_v_o),       64'(exp_rv[cyc]));
            check("r_addr", 64'(bus.r_addr_o),    64'(exp_raddr[cyc]));
            check("w_en",   64'(bus.w_en_o),      64'(exp_wen[cyc]));
            check("w_addr", 64'(bus.w_addr_o),
                  (cyc >= LAT) ? 64'(exp_raddr[cyc-LAT]) : 64'd0);
        end
    end

    initial begin
        int a;
        logic [L-1:0][AW-1:0] addr_lo, addr_hi;
        addr_lo = {3'd3, 3'd2, 3'd1, 3'd0};
        addr_hi = {3'd7, 3'd6, 3'd5, 3'd4};
        bus.cmd_v_i = 1'b0; bus.cmd_vl_i = '0; bus.cmd_we_i = 1'b0; bus.stall_i = 1'b0;
        for (int c = 0; c < NCYC; c++) stall_tab[c] = 1'b0;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.cmd_ready_o), 64'd0);
        check("rst_busy",  64'(bus.busy_o),      64'd0);
        check("rst_rv",    64'(bus.r_v_o),       64'd0);
        check("rst_wen",   64'(bus.w_en_o),      64'd0);
        check("rst_done",  64'(bus.done_o),      64'd0);
        reset_i = 1'b0;
        cyc = 0;
        idle_from = 0;
        chk_en = 1'b1;

        // Full vector, writes enabled
        a = cyc;
        drive(1'b1, 8, 1'b1);
        check("pin1_rv1",   64'(exp_rv[a+1]),    64'hf);
        check("pin1_ra1",   64'(exp_raddr[a+1]), 64'(addr_lo));
        check("pin1_ra2",   64'(exp_raddr[a+2]), 64'(addr_hi));
        check("pin1_wen3",  64'(exp_wen[a+3]),   64'hf);
        check("pin1_done4", 64'(exp_done[a+4]),  64'd1);
        check("pin1_idle",  64'(idle_from),      64'(a+5));
        idle_cycles(5);

        // Partial last step
        a = cyc;
        drive(1'b1, 5, 1'b1);
        check("pin2_rv2",   64'(exp_rv[a+2]),   64'h1);
        check("pin2_wen3",  64'(exp_wen[a+3]),  64'h1);
        check("pin2_done4", 64'(exp_done[a+4]), 64'd1);
        idle_cycles(4);

        // Zero length, then over-length clamp
        a = cyc;
        drive(1'b1, 0, 1'b1);
        check("pin3_done1", 64'(exp_done[a+1]), 64'd1);
        idle_cycles(1);
        a = cyc;
        drive(1'b1, 12, 1'b1);
        check("pin3b_ra2",   64'(exp_raddr[a+2]), 64'(addr_hi));
        check("pin3b_done4", 64'(exp_done[a+4]),  64'd1);
        idle_cycles(4);

        // Stall on cycles 2-3 of the op, with and without write-back
        a = cyc;
        stall_tab[a+2] = 1'b1; stall_tab[a+3] = 1'b1;
        drive(1'b1, 8, 1'b1);
        check("pin4_rv4",   64'(exp_rv[a+4]),   64'hf);
        check("pin4_wen5",  64'(exp_wen[a+5]),  64'hf);
        check("pin4_done6", 64'(exp_done[a+6]), 64'd1);
        idle_cycles(6);
        a = cyc;
        stall_tab[a+2] = 1'b1; stall_tab[a+3] = 1'b1;
        drive(1'b1, 8, 1'b0);
        check("pin4b_wen2", 64'(exp_wen[a+2]),  64'h0);
        check("pin4b_done", 64'(exp_done[a+6]), 64'd1);
        idle_cycles(6);

        // Command valid held high: back-to-back ops
        for (int j = 0; j < 150; j++) drive(1'b1, $urandom_range(12, 0), 1'($urandom_range(1, 0)));

        // Random stalls, commands and lengths
        for (int c = cyc; c < cyc + 600; c++) stall_tab[c] = ($urandom_range(3, 0) == 0);
        for (int j = 0; j < 600; j++)
            drive(1'($urandom_range(9, 0) < 7), $urandom_range(12, 0), 1'($urandom_range(1, 0)));
        idle_cycles(12);

        // Reset in the middle of a full-vector op
        a = cyc;
        drive(1'b1, 8, 1'b1);
        drive(1'b0, 0, 1'b0);
        bus.cmd_v_i = 1'b0; bus.stall_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        check("mid_rst_rv",    64'(bus.r_v_o),       64'd0);
        check("mid_rst_raddr", 64'(bus.r_addr_o),    64'd0);
        check("mid_rst_wen",   64'(bus.w_en_o),      64'd0);
        check("mid_rst_waddr", 64'(bus.w_addr_o),    64'd0);
        check("mid_rst_busy",  64'(bus.busy_o),      64'd0);
        check("mid_rst_ready", 64'(bus.cmd_ready_o), 64'd0);
        #1 reset_i = 1'b0;
        clear_model();
        idle_from = cyc;
        exp_ready[cyc] = 1'b1;
        exp_busy[cyc]  = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        a = cyc;
        drive(1'b1, 4, 1'b1);
        check("pin5_done3", 64'(exp_done[a+3]), 64'd1);
        idle_cycles(5);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
